// File: rtl/netwalk_action_engine_pipe.sv
// netwalk_action_engine_pipe
//
// Applies a list of per-packet header actions (SET / DEC / INC / DROP) to a
// packet header, one action slot per clock, then presents the modified header
// downstream with a valid/ready handshake.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : upstream handshake; in_ready is high only when idle
//   pkt_header_in     : header to modify (HDR_W bits)
//   act_valid/op/off/len/val : packed per-slot action fields, slot i at [i*W +: W]
//   out_valid/out_ready : downstream handshake
//   pkt_header_out    : modified header, stable while out_valid is high
//   err_oob           : sticky flag, a valid slot addressed outside the header
//                       or asked for a field wider than VAL_W
//   pkt_count         : packets emitted (wraps)
//   drop_count        : packets dropped (wraps)

module netwalk_action_engine_pipe #(
    parameter int unsigned HDR_W   = 512,
    parameter int unsigned NUM_ACT = 8,
    parameter int unsigned OFF_W   = 9,
    parameter int unsigned LEN_W   = 6,
    parameter int unsigned VAL_W   = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [HDR_W-1:0]         pkt_header_in,
    input  logic [NUM_ACT-1:0]       act_valid,
    input  logic [2*NUM_ACT-1:0]     act_op,
    input  logic [OFF_W*NUM_ACT-1:0] act_off,
    input  logic [LEN_W*NUM_ACT-1:0] act_len,
    input  logic [VAL_W*NUM_ACT-1:0] act_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HDR_W-1:0]         pkt_header_out,
    output logic                     err_oob,
    output logic [31:0]              pkt_count,
    output logic [31:0]              drop_count
);

    localparam int unsigned IDX_W = (NUM_ACT > 1) ? $clog2(NUM_ACT) : 1;

    localparam logic [1:0] OpSet  = 2'b00;
    localparam logic [1:0] OpDec  = 2'b01;
    localparam logic [1:0] OpInc  = 2'b10;
    localparam logic [1:0] OpDrop = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StOut} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [HDR_W-1:0]         hdr_q, hdr_d;
    logic                     drop_q, drop_d;
    logic                     err_q, err_d;
    logic [31:0]              pkt_cnt_q, pkt_cnt_d;
    logic [31:0]              drop_cnt_q, drop_cnt_d;
    logic [NUM_ACT-1:0]       valid_q, valid_d;
    logic [2*NUM_ACT-1:0]     op_q, op_d;
    logic [OFF_W*NUM_ACT-1:0] off_q, off_d;
    logic [LEN_W*NUM_ACT-1:0] len_q, len_d;
    logic [VAL_W*NUM_ACT-1:0] val_q, val_d;

    // Current slot, selected by idx_q from the captured action vectors
    logic             cur_en;
    logic [1:0]       cur_op;
    logic [OFF_W-1:0] cur_off;
    logic [LEN_W-1:0] cur_len;
    logic [VAL_W-1:0] cur_val;

    assign cur_en  = valid_q[idx_q];
    assign cur_op  = op_q[2*32'(idx_q) +: 2];
    assign cur_off = off_q[OFF_W*32'(idx_q) +: OFF_W];
    assign cur_len = len_q[LEN_W*32'(idx_q) +: LEN_W];
    assign cur_val = val_q[VAL_W*32'(idx_q) +: VAL_W];

    logic             len_zero, len_big, range_bad;
    logic             slot_apply, slot_err;
    logic [VAL_W-1:0] field_mask, field_old, field_new;
    logic [HDR_W-1:0] hdr_upd;

    always_comb begin
        len_zero   = (cur_len == '0);
        len_big    = (32'(cur_len) > VAL_W);
        range_bad  = ((32'(cur_off) + 32'(cur_len)) > HDR_W);
        // Zero length is a silent no-op; the other two skips are errors
        slot_apply = cur_en && !len_zero && !len_big && !range_bad;
        slot_err   = cur_en && !len_zero && (len_big || range_bad);

        // Only meaningful when slot_apply, i.e. 1 <= len <= VAL_W
        field_mask = {VAL_W{1'b1}} >> (VAL_W - 32'(cur_len));
        field_old  = VAL_W'(hdr_q >> cur_off) & field_mask;

        field_new = field_old;
        unique case (cur_op)
            OpSet:   field_new = cur_val;
            OpDec:   field_new = (field_old == '0) ? '0 : field_old - 1'b1;
            OpInc:   field_new = field_old + 1'b1;
            default: field_new = field_old;
        endcase
        field_new = field_new & field_mask;

        hdr_upd = (hdr_q & ~(HDR_W'(field_mask) << cur_off))
                | (HDR_W'(field_new) << cur_off);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hdr_d      = hdr_q;
        drop_d     = drop_q;
        err_d      = err_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        valid_d    = valid_q;
        op_d       = op_q;
        off_d      = off_q;
        len_d      = len_q;
        val_d      = val_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    hdr_d   = pkt_header_in;
                    valid_d = act_valid;
                    op_d    = act_op;
                    off_d   = act_off;
                    len_d   = act_len;
                    val_d   = act_val;
                    idx_d   = '0;
                    drop_d  = 1'b0;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (slot_apply) begin
                    if (cur_op == OpDrop) begin
                        drop_d = 1'b1;
                    end else begin
                        hdr_d = hdr_upd;
                    end
                end
                if (slot_err) begin
                    err_d = 1'b1;
                end
                if (idx_q == IDX_W'(NUM_ACT - 1)) begin
                    if (drop_d) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StOut;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            hdr_q      <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            valid_q    <= '0;
            op_q       <= '0;
            off_q      <= '0;
            len_q      <= '0;
            val_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hdr_q      <= hdr_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            off_q      <= off_d;
            len_q      <= len_d;
            val_q      <= val_d;
        end
    end

    // Gated by reset so the engine refuses work while reset is held
    assign in_ready       = (state_q == StIdle) && reset;
    assign out_valid      = (state_q == StOut);
    assign pkt_header_out = hdr_q;
    assign err_oob        = err_q;
    assign pkt_count      = pkt_cnt_q;
    assign drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_netwalk_action_engine_pipe.sv
// Directed testbench for netwalk_action_engine_pipe (default parameters).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.

module tb_netwalk_action_engine_pipe;

    localparam int HDR_W   = 512;
    localparam int NUM_ACT = 8;
    localparam int OFF_W   = 9;
    localparam int LEN_W   = 6;
    localparam int VAL_W   = 48;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [HDR_W-1:0]         pkt_header_in;
    logic [NUM_ACT-1:0]       act_valid;
    logic [2*NUM_ACT-1:0]     act_op;
    logic [OFF_W*NUM_ACT-1:0] act_off;
    logic [LEN_W*NUM_ACT-1:0] act_len;
    logic [VAL_W*NUM_ACT-1:0] act_val;
    logic                     out_valid;
    logic                     out_ready;
    logic [HDR_W-1:0]         pkt_header_out;
    logic                     err_oob;
    logic [31:0]              pkt_count;
    logic [31:0]              drop_count;

    int checks = 0;
    int errors = 0;

    netwalk_action_engine_pipe #(
        .HDR_W   (HDR_W),
        .NUM_ACT (NUM_ACT),
        .OFF_W   (OFF_W),
        .LEN_W   (LEN_W),
        .VAL_W   (VAL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pkt_header_in  (pkt_header_in),
        .act_valid      (act_valid),
        .act_op         (act_op),
        .act_off        (act_off),
        .act_len        (act_len),
        .act_val        (act_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pkt_header_out (pkt_header_out),
        .err_oob        (err_oob),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_acts();
        act_valid = '0;
        act_op    = '0;
        act_off   = '0;
        act_len   = '0;
        act_val   = '0;
    endtask

    task automatic set_slot(input int s, input logic [1:0] op, input int off, input int len,
                            input logic [VAL_W-1:0] val);
        act_valid[s]                 = 1'b1;
        act_op[s*2 +: 2]             = op;
        act_off[s*OFF_W +: OFF_W]    = OFF_W'(off);
        act_len[s*LEN_W +: LEN_W]    = LEN_W'(len);
        act_val[s*VAL_W +: VAL_W]    = val;
    endtask

    // Offer one packet; returns at the falling edge after the handshake edge.
    // Inputs are then scrambled so any late sampling corrupts the result.
    task automatic send(input logic [HDR_W-1:0] hdr);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: in_ready=%b required 1", in_ready);
        end
        pkt_header_in = hdr;
        in_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid      = 1'b0;
        pkt_header_in = '1;
        act_valid     = '1;
        act_op        = '1;
        act_off       = '0;
        act_len       = '1;
        act_val       = '1;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        pkt_header_in = '0;
        clear_acts();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || err_oob !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b err_oob=%b required 0 0 0",
                     in_ready, out_valid, err_oob);
        end
        checks++;
        if (pkt_header_out !== '0 || pkt_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: hdr=%h pkt=%0d drop=%0d required 0 0 0",
                     pkt_header_out, pkt_count, drop_count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_set();
        logic [HDR_W-1:0] base, exp;
        int cyc;
        base = {16{32'h12345678}};
        exp  = base;
        exp[47:0] = 48'hAABBCCDDEEFF;
        clear_acts();
        set_slot(0, 2'b00, 0, 48, 48'hAABBCCDDEEFF);
        send(base);
        wait_out(cyc);
        checks++;
        if (cyc !== NUM_ACT) begin
            errors++;
            $display("FAIL set_latency: cycles=%0d required %0d", cyc, NUM_ACT);
        end
        checks++;
        if (pkt_header_out !== exp) begin
            errors++;
            $display("FAIL set_header: got=%h required %h", pkt_header_out, exp);
        end
        accept();
        checks++;
        if (pkt_count !== 32'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL set_accept: pkt=%0d out_valid=%b in_ready=%b required 1 0 1",
                     pkt_count, out_valid, in_ready);
        end
    endtask

    task automatic test_dec_inc();
        logic [HDR_W-1:0] base, exp;
        int cyc;
        base = '0;
        base[31:0] = 32'h07FF0100;
        exp  = '0;
        exp[31:0]  = 32'h08000000;
        clear_acts();
        set_slot(0, 2'b01, 8, 8, '0);
        set_slot(1, 2'b01, 8, 8, '0);
        set_slot(2, 2'b10, 16, 8, '0);
        set_slot(3, 2'b10, 24, 4, '0);
        send(base);
        wait_out(cyc);
        checks++;
        if (cyc !== NUM_ACT || pkt_header_out !== exp) begin
            errors++;
            $display("FAIL dec_inc: cycles=%0d hdr=%h required %0d %h",
                     cyc, pkt_header_out[31:0], NUM_ACT, exp[31:0]);
        end
        accept();
        checks++;
        if (pkt_count !== 32'd2) begin
            errors++;
            $display("FAIL dec_inc_count: pkt=%0d required 2", pkt_count);
        end
    endtask

    task automatic test_overlap();
        logic [HDR_W-1:0] exp;
        int cyc;
        exp = '0;
        exp[39:32] = 8'h22;
        clear_acts();
        set_slot(2, 2'b00, 32, 8, 48'h000000000011);
        set_slot(4, 2'b01, 32, 8, '0);
        set_slot(5, 2'b00, 32, 8, 48'hFFFFFFFFFF22);
        send('0);
        wait_out(cyc);
        checks++;
        if (pkt_header_out !== exp) begin
            errors++;
            $display("FAIL overlap: hdr=%h required %h", pkt_header_out[63:0], exp[63:0]);
        end
        accept();
    endtask

    task automatic test_drop();
        int n;
        logic saw;
        clear_acts();
        set_slot(0, 2'b00, 0, 8, 48'h55);
        set_slot(3, 2'b11, 0, 8, '0);
        send({16{32'hCAFEF00D}});
        n   = 0;
        saw = 1'b0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) saw = 1'b1;
        end
        checks++;
        if (n !== NUM_ACT || saw !== 1'b0) begin
            errors++;
            $display("FAIL drop_flow: cycles=%0d saw_out_valid=%b required %0d 0",
                     n, saw, NUM_ACT);
        end
        checks++;
        if (drop_count !== 32'd1 || pkt_count !== 32'd3) begin
            errors++;
            $display("FAIL drop_counts: drop=%0d pkt=%0d required 1 3", drop_count, pkt_count);
        end
    endtask

    task automatic test_oob();
        logic [HDR_W-1:0] base, exp;
        int cyc;
        checks++;
        if (err_oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_before: err_oob=%b required 0", err_oob);
        end
        base = {16{32'hDEADBEEF}};
        clear_acts();
        set_slot(0, 2'b00, 500, 16, 48'hFFFF);
        send(base);
        wait_out(cyc);
        checks++;
        if (cyc !== NUM_ACT || pkt_header_out !== base || err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_packet: cycles=%0d err_oob=%b hdr_hi=%h required %0d 1 %h",
                     cyc, err_oob, pkt_header_out[511:448], NUM_ACT, base[511:448]);
        end
        accept();
        exp = '0;
        exp[7:0] = 8'h5A;
        clear_acts();
        set_slot(0, 2'b00, 0, 8, 48'h5A);
        send('0);
        wait_out(cyc);
        checks++;
        if (pkt_header_out !== exp || err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_sticky: hdr=%h err_oob=%b required %h 1",
                     pkt_header_out[31:0], err_oob, exp[31:0]);
        end
        accept();
        checks++;
        if (pkt_count !== 32'd5) begin
            errors++;
            $display("FAIL oob_count: pkt=%0d required 5", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        logic [HDR_W-1:0] exp;
        int cyc;
        int bad;
        exp = '0;
        exp[102:100] = 3'b110;
        clear_acts();
        set_slot(7, 2'b10, 100, 3, '0);
        begin
            logic [HDR_W-1:0] base;
            base = '0;
            base[102:100] = 3'b101;
            send(base);
        end
        wait_out(cyc);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || pkt_header_out !== exp) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: unstable_cycles=%0d required 0 (hdr=%h)",
                     bad, pkt_header_out[127:96]);
        end
        accept();
        checks++;
        if (pkt_count !== 32'd6 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accept: pkt=%0d out_valid=%b required 6 0",
                     pkt_count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic saw;
        clear_acts();
        set_slot(0, 2'b00, 0, 16, 48'h1234);
        send({16{32'hA5A5A5A5}});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || pkt_header_out !== '0
            || err_oob !== 1'b0 || pkt_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b err=%b pkt=%0d drop=%0d hdr_lo=%h required all 0",
                     out_valid, in_ready, err_oob, pkt_count, drop_count, pkt_header_out[31:0]);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || in_ready !== 1'b1 || pkt_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_after: saw_out_valid=%b in_ready=%b pkt=%0d required 0 1 0",
                     saw, in_ready, pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_dec_inc();
        test_overlap();
        test_drop();
        test_oob();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
